// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// mult/multu take 5 busy cycles and div/divu take 10. Results land in HI/LO
// on the edge where busy falls. mthi/mtlo writes are accepted only while idle.
// Optional feature: define MDU_MADD_EN to make way=101 a signed
// multiply-accumulate (madd) into {HI,LO}.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  way,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIw,
    input  logic        LOw,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MADD  = 3'b101
    } op_e;

    logic [3:0]  count;
    op_e         op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
`ifdef MDU_MADD_EN
    logic [63:0] acc_q;
`endif

    logic        way_valid;
    logic        accept;
    logic        is_div_way;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               signed_div;
    logic        [31:0] dvd_mag;
    logic        [31:0] dvs_mag;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] quot;
    logic        [31:0] rem;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;
    logic               res_write;

    assign busy   = (count != 4'd0);
    assign accept = start && !busy && way_valid;
    assign is_div_way = (way == OP_DIV) || (way == OP_DIVU);

    // Decode which operation codes this build accepts.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves the
        // variable unassigned, which would infer a latch.
        way_valid = 1'b0;
        case (way)
            3'b001, 3'b010, 3'b011, 3'b100: way_valid = 1'b1;
`ifdef MDU_MADD_EN
            3'b101:                         way_valid = 1'b1;
`endif
            default:                        way_valid = 1'b0;
        endcase
    end

    // Compute the result from the latched operands; consumed on the final busy edge.
    always_comb begin
        prod_s = $signed(a_q) * $signed(b_q);
        prod_u = {32'd0, a_q} * {32'd0, b_q};

        // Divide on magnitudes and fix signs afterwards: quotient truncates
        // toward zero, remainder follows the dividend. This also makes
        // 0x80000000 / -1 come out as 0x80000000 rem 0 without a special case.
        signed_div = (op_q == OP_DIV);
        dvd_mag    = (signed_div && a_q[31]) ? (~a_q + 32'd1) : a_q;
        dvs_mag    = (signed_div && b_q[31]) ? (~b_q + 32'd1) : b_q;
        if (dvs_mag != 32'd0) begin
            q_mag = dvd_mag / dvs_mag;
            r_mag = dvd_mag % dvs_mag;
        end else begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end
        quot = (signed_div && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
        rem  = (signed_div && a_q[31])             ? (~r_mag + 32'd1) : r_mag;

        res_write = 1'b1;
        res_hi    = HI;
        res_lo    = LO;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                // A zero divisor still burns the full latency but writes nothing.
                res_write = (b_q != 32'd0);
                res_hi    = rem;
                res_lo    = quot;
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi, res_lo} = acc_q + prod_s;
`endif
            default:  res_write = 1'b0;
        endcase
    end

    // Accept operations, latch operands and run the busy counter.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: operand latches are reset too, so an aborted operation leaves
        // no stale state behind.
        if (!reset) begin
            count <= 4'd0;
            op_q  <= OP_MULT;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
`ifdef MDU_MADD_EN
            acc_q <= 64'd0;
`endif
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            a_q   <= A;
            b_q   <= B;
            op_q  <= op_e'(way);
            count <= is_div_way ? 4'd10 : 4'd5;
`ifdef MDU_MADD_EN
            acc_q <= {HI, LO};
`endif
        end else if (busy) begin
            count <= count - 4'd1;
        end
    end

    // HI/LO: result load on the last busy edge, otherwise idle mthi/mtlo writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (count == 4'd1) begin
            if (res_write) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end else if (!busy && !accept) begin
            if (HIw) HI <= A;
            if (LOw) LO <= A;
        end
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
REQ-002 start  input  1  begin a mult/div operation; sampled at the rising edge.
REQ-003 way  input  3  operation select: 001 mult, 010 multu, 011 div, 100 divu; all other codes are invalid.
REQ-004 A  input  32  operand rs; also the data source for mthi/mtlo.
REQ-005 B  input  32  operand rt.
REQ-006 HIw  input  1  write A into HI (mthi).
REQ-007 LOw  input  1  write A into LO (mtlo).
REQ-008 busy  output  1  an operation is in progress.
REQ-009 HI  output  32  HI register value (registered).
REQ-010 LO  output  32  LO register value (registered).

Function
REQ-011 The block SHALL accept an operation at an edge where start=1, busy=0 and way is valid.
- On accept it SHALL latch A and B.
- On accept it SHALL load an internal cycle counter with 5 for mult/multu and 10 for div/divu.
REQ-012 busy SHALL equal (counter != 0), so busy is high for exactly 5 (mult) or 10 (div) cycles following the accept edge.
REQ-013 The counter SHALL decrement by 1 each edge while nonzero.
- At the edge where it goes 1 -> 0, HI and LO SHALL load the result.
- The result SHALL be visible in the same cycle that busy falls.
REQ-014 Multiply results:
- mult: {HI,LO} = signed 64-bit product of A and B.
- multu: {HI,LO} = unsigned 64-bit product.
REQ-015 Divide results:
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned LO = quotient, HI = remainder.
REQ-016 div with A=0x80000000 and B=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-017 Divide by zero (B=0, div or divu) SHALL still run the full 10 busy cycles and SHALL leave HI and LO unchanged.
REQ-018 start asserted while busy=1 SHALL be ignored; no restart and no queueing.
REQ-019 start with an invalid way SHALL be ignored; busy stays 0.
REQ-020 HIw/LOw with busy=0 SHALL write A into HI/LO at the edge; HIw and LOw together SHALL write both.
REQ-021 HIw/LOw with busy=1 SHALL be ignored.
REQ-022 If start is accepted in the same cycle as HIw/LOw, start SHALL win and HIw/LOw SHALL be ignored.
REQ-023 HI and LO SHALL change only on result load (REQ-013), HIw/LOw writes (REQ-020), or reset.

Reset
REQ-024 reset=0 SHALL immediately, without waiting for clk, force HI=0, LO=0, counter=0 and busy=0, and SHALL discard any latched operands.
REQ-025 Reset asserted mid-operation SHALL abort the operation; no result is written after reset is released.
REQ-026 After reset release, the first edge with a valid start SHALL be accepted normally.

Configuration
REQ-027 When macro MDU_MADD_EN is defined, way=101 SHALL be a valid madd operation.
- Result: {HI,LO} = {HI,LO} + signed product of A and B, using the HI/LO values at the accept edge.
- Latency: 5 busy cycles.
REQ-028 When MDU_MADD_EN is undefined, way=101 SHALL be invalid and ignored per REQ-019.

Verification
REQ-029 The bench SHALL cover at least these scenarios:
- mult A=0xFFFFFFFF, B=0x00000002 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu A=0xFFFFFFFF, B=0x00000002 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9, B=0x00000002 -> busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Preload HI=0x11111111 via HIw; divu A=7, B=0 -> busy 10 cycles; HI=0x11111111 and LO unchanged.
- Start mult; assert HIw with A=0x12345678 in busy cycle 2 -> HI unchanged; HIw after busy falls -> HI=0x12345678 next edge.
- Start div; drive reset=0 in busy cycle 3 -> busy, HI and LO go to 0 before the next clk edge; no later result write.
